stack_unit: RTL and testbench
=============================

// Module: stack_unit
// PURPOSE
//   Parametrised hardware stack with registered top-of-stack, pop data port and sticky error flags.
//   Next-generation replacement for the single SP register + decrement path of the multicycle datapath.
//   Holds CALL/RET return addresses and PUSH/POP operands on-chip, so they no longer cost data-memory cycles.
//   The controller drives push/pop; the datapath consumes top, pop_data and count.
// PARAMETERS
//   DATA_W  32  width of one stack entry
//   DEPTH   16  number of entries (>=2)
//   AFULL   14  count threshold at/above which almost_full asserts (1..DEPTH)
//   CNT_W   $clog2(DEPTH+1)  derived, width of count; not to be overridden
// PORTS
//   clk          in   1       rising-edge clock, single domain
//   reset        in   1       synchronous, active-high
//   push         in   1       write data_in as new top this cycle
//   pop          in   1       remove top this cycle
//   data_in      in   DATA_W  push data
//   err_clr      in   1       clear sticky overflow/underflow
//   top          out  DATA_W  registered copy of current top entry (0 when empty)
//   pop_data     out  DATA_W  value removed by last accepted pop
//   pop_valid    out  1       1-cycle pulse, pop_data valid
//   count        out  CNT_W   number of stored entries
//   empty        out  1       count==0
//   full         out  1       count==DEPTH
//   almost_full  out  1       count>=AFULL
//   overflow     out  1       sticky: push rejected while full
//   underflow    out  1       sticky: pop rejected while empty
// BEHAVIOUR
//   Reset (sync, high): count=0, top=0, pop_data=0, pop_valid=0, overflow=0, underflow=0.
//     Storage array not cleared. reset overrides every other input in that cycle.
//   All state updates on the rising clk edge; empty/full/almost_full combinational from count.
//   Storage: mem[0..DEPTH-1], mem[count-1] is top; grows upward.
//   Op decode per cycle ({push,pop}):
//     00 idle: no state change; pop_valid=0.
//     10 push, !full: mem[count]<=data_in; count+1; top<=data_in.
//     10 push, full: rejected, no state change; overflow<=1.
//     01 pop, !empty: pop_data<=top; pop_valid<=1; count-1;
//        top<=mem[count-2] if count>=2, else 0.
//     01 pop, empty: rejected; underflow<=1; pop_valid=0; pop_data holds.
//     11 replace, !empty: mem[count-1]<=data_in; top<=data_in; pop_data<=old top;
//        pop_valid<=1; count unchanged. Legal when full, no overflow.
//     11 bypass, empty: pop_data<=data_in; pop_valid<=1; count stays 0, top stays 0; no error.
//   Latency: top reflects an accepted op on the cycle after the edge; pop_data/pop_valid likewise (1 cycle).
//   pop_valid is a single-cycle pulse; back-to-back pops give back-to-back pulses.
//   Sticky flags: set by rejected ops, cleared only by err_clr or reset.
//     err_clr and a new error event in the same cycle -> flag stays 1 (set wins).
//   Arithmetic: count is unsigned CNT_W. Never wraps: increment blocked at DEPTH, decrement blocked at 0.
//   Rejected ops never modify mem, count or top.
//   No X on outputs after reset, regardless of storage contents.
// TESTING
//   T1 reset: assert reset 2 cycles with push=1 -> count=0, empty=1, top=0, flags 0, pop_valid 0.
//   T2 fill/drain: push 0x11..0x10+DEPTH.
//      Check almost_full rises at count=AFULL, full=1 at 16, top=0x20.
//      Then pop 16x: pop_data 0x20 down to 0x11 with pop_valid every cycle; empty=1 at end.
//   T3 overflow: full stack, push 0xDEAD -> count=16, top unchanged, overflow=1.
//      Pulse err_clr -> overflow=0.
//   T4 underflow: empty, pop -> underflow=1, pop_valid=0.
//      Pop again with err_clr=1 in the same cycle -> underflow stays 1.
//   T5 replace/bypass: stack [5,7], push+pop 9 -> pop_data=7, top=9, count=2.
//      Empty, push+pop 3 -> pop_data=3, pop_valid=1, count=0, no flags.
//   T6 reset mid-operation: push 3 entries, assert reset with pop=1 -> count=0, pop_valid=0.
//      Next push 0x42 -> top=0x42, count=1.

Source files
------------

// File: rtl/stack_unit.sv
// ============================================================================
// Module   : stack_unit
// Purpose  : Parametrised LIFO with registered top-of-stack, pop data port
//            and sticky overflow/underflow flags.
// Revision : 1.0
// ============================================================================
`default_nettype none

module stack_unit #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16,
  parameter int AFULL  = 14,
  parameter int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] data_in,
  input  logic              err_clr,
  output logic [DATA_W-1:0] top,
  output logic [DATA_W-1:0] pop_data,
  output logic              pop_valid,
  output logic [CNT_W-1:0]  count,
  output logic              empty,
  output logic              full,
  output logic              almost_full,
  output logic              overflow,
  output logic              underflow
);

  localparam int             AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0] C_DEPTH = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] C_AFULL = CNT_W'(AFULL);
  localparam logic [CNT_W-1:0] C_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] C_TWO   = CNT_W'(2);

  logic [DATA_W-1:0] mem [DEPTH];

  logic             do_push, rej_push, do_pop, rej_pop, do_repl, do_bypass;
  logic [CNT_W-1:0] idx_top, idx_below;

  assign empty       = (count == '0);
  assign full        = (count == C_DEPTH);
  assign almost_full = (count >= C_AFULL);

  assign do_push   =  push & ~pop & ~full;
  assign rej_push  =  push & ~pop &  full;
  assign do_pop    = ~push &  pop & ~empty;
  assign rej_pop   = ~push &  pop &  empty;
  assign do_repl   =  push &  pop & ~empty;
  assign do_bypass =  push &  pop &  empty;

  assign idx_top   = count - C_ONE;
  assign idx_below = count - C_TWO;

  // Storage is deliberately not reset; outputs never expose it without a write first.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (do_push) mem[count[AW-1:0]]   <= data_in;
      if (do_repl) mem[idx_top[AW-1:0]] <= data_in;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count     <= '0;
      top       <= '0;
      pop_data  <= '0;
      pop_valid <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      pop_valid <= 1'b0;

      if (do_push) begin
        count <= count + C_ONE;
        top   <= data_in;
      end

      if (do_pop) begin
        pop_data  <= top;
        pop_valid <= 1'b1;
        count     <= count - C_ONE;
        top       <= (count >= C_TWO) ? mem[idx_below[AW-1:0]] : '0;
      end

      if (do_repl) begin
        pop_data  <= top;
        pop_valid <= 1'b1;
        top       <= data_in;
      end

      if (do_bypass) begin
        pop_data  <= data_in;
        pop_valid <= 1'b1;
      end

      // A new error in the same cycle as err_clr keeps the flag set.
      if (rej_push)     overflow <= 1'b1;
      else if (err_clr) overflow <= 1'b0;

      if (rej_pop)      underflow <= 1'b1;
      else if (err_clr) underflow <= 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_stack_unit.sv
// ============================================================================
// Module   : tb_stack_unit
// Purpose  : Directed self-checking bench for stack_unit.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_stack_unit;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 16;
  localparam int AFULL  = 14;
  localparam int CNT_W  = $clog2(DEPTH + 1);

  logic              clk = 1'b0;
  logic              reset, push, pop, err_clr;
  logic [DATA_W-1:0] data_in;
  logic [DATA_W-1:0] top, pop_data;
  logic              pop_valid, empty, full, almost_full, overflow, underflow;
  logic [CNT_W-1:0]  count;

  int checks   = 0;
  int failures = 0;

  stack_unit #(.DATA_W(DATA_W), .DEPTH(DEPTH), .AFULL(AFULL)) dut (
    .clk(clk), .reset(reset), .push(push), .pop(pop), .data_in(data_in),
    .err_clr(err_clr), .top(top), .pop_data(pop_data), .pop_valid(pop_valid),
    .count(count), .empty(empty), .full(full), .almost_full(almost_full),
    .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  // Apply one cycle of inputs, then sample 1 time unit after the edge.
  task automatic cyc(input logic rs, input logic ps, input logic pp,
                     input logic [DATA_W-1:0] d, input logic ec);
    reset = rs; push = ps; pop = pp; data_in = d; err_clr = ec;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [DATA_W-1:0] obs,
                     input logic [DATA_W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    cyc(1, 0, 0, '0, 0);

    // T1: reset wins over push
    cyc(1, 1, 0, 32'hAA, 0);
    cyc(1, 1, 0, 32'hAA, 0);
    chk("t1_count", 32'(count), 0);
    chk("t1_empty", 32'(empty), 1);
    chk("t1_full", 32'(full), 0);
    chk("t1_top", top, 0);
    chk("t1_ovf", 32'(overflow), 0);
    chk("t1_udf", 32'(underflow), 0);
    chk("t1_pv", 32'(pop_valid), 0);
    chk("t1_pd", pop_data, 0);

    // T2: fill
    for (int i = 1; i <= DEPTH; i++) begin
      cyc(0, 1, 0, 32'(32'h10 + i), 0);
      chk("t2_fill_count", 32'(count), 32'(i));
      chk("t2_fill_top", top, 32'(32'h10 + i));
      chk("t2_fill_afull", 32'(almost_full), (i >= AFULL) ? 1 : 0);
      chk("t2_fill_full", 32'(full), (i == DEPTH) ? 1 : 0);
    end
    chk("t2_top_full", top, 32'h20);
    // T2: drain
    for (int k = 1; k <= DEPTH; k++) begin
      cyc(0, 0, 1, '0, 0);
      chk("t2_drain_pd", pop_data, 32'(32'h21 - k));
      chk("t2_drain_pv", 32'(pop_valid), 1);
      chk("t2_drain_count", 32'(count), 32'(DEPTH - k));
      chk("t2_drain_top", top, (k < DEPTH) ? 32'(32'h20 - k) : 32'h0);
    end
    chk("t2_empty", 32'(empty), 1);
    cyc(0, 0, 0, '0, 0);
    chk("t2_pv_pulse", 32'(pop_valid), 0);
    chk("t2_pd_hold", pop_data, 32'h11);

    // T3: overflow
    for (int i = 1; i <= DEPTH; i++) cyc(0, 1, 0, 32'(32'h10 + i), 0);
    cyc(0, 1, 0, 32'hDEAD, 0);
    chk("t3_count", 32'(count), 32'(DEPTH));
    chk("t3_top", top, 32'h20);
    chk("t3_ovf", 32'(overflow), 1);
    cyc(0, 0, 0, '0, 0);
    chk("t3_ovf_sticky", 32'(overflow), 1);
    cyc(0, 0, 0, '0, 1);
    chk("t3_ovf_clr", 32'(overflow), 0);
    // overflowed push must not have corrupted storage
    cyc(0, 0, 1, '0, 0);
    chk("t3_pop_pd", pop_data, 32'h20);
    chk("t3_pop_top", top, 32'h1F);

    // T4: underflow
    for (int k = 1; k < DEPTH; k++) cyc(0, 0, 1, '0, 0);
    chk("t4_empty", 32'(empty), 1);
    chk("t4_last_pd", pop_data, 32'h11);
    cyc(0, 0, 1, '0, 0);
    chk("t4_udf", 32'(underflow), 1);
    chk("t4_pv", 32'(pop_valid), 0);
    chk("t4_pd_hold", pop_data, 32'h11);
    chk("t4_count", 32'(count), 0);
    cyc(0, 0, 1, '0, 1);
    chk("t4_udf_setwins", 32'(underflow), 1);
    cyc(0, 0, 0, '0, 1);
    chk("t4_udf_clr", 32'(underflow), 0);

    // T5: replace and bypass
    cyc(0, 1, 0, 32'd5, 0);
    cyc(0, 1, 0, 32'd7, 0);
    cyc(0, 1, 1, 32'd9, 0);
    chk("t5_repl_pd", pop_data, 32'd7);
    chk("t5_repl_pv", 32'(pop_valid), 1);
    chk("t5_repl_top", top, 32'd9);
    chk("t5_repl_count", 32'(count), 2);
    cyc(0, 0, 1, '0, 0);
    chk("t5_pop1_pd", pop_data, 32'd9);
    chk("t5_pop1_top", top, 32'd5);
    cyc(0, 0, 1, '0, 0);
    chk("t5_pop2_pd", pop_data, 32'd5);
    chk("t5_pop2_top", top, 32'd0);
    cyc(0, 1, 1, 32'd3, 0);
    chk("t5_byp_pd", pop_data, 32'd3);
    chk("t5_byp_pv", 32'(pop_valid), 1);
    chk("t5_byp_count", 32'(count), 0);
    chk("t5_byp_top", top, 32'd0);
    chk("t5_byp_ovf", 32'(overflow), 0);
    chk("t5_byp_udf", 32'(underflow), 0);

    // T6: reset mid-operation
    cyc(0, 1, 0, 32'hA1, 0);
    cyc(0, 1, 0, 32'hA2, 0);
    cyc(0, 1, 0, 32'hA3, 0);
    chk("t6_pre_count", 32'(count), 3);
    cyc(1, 0, 1, '0, 0);
    chk("t6_rst_count", 32'(count), 0);
    chk("t6_rst_pv", 32'(pop_valid), 0);
    chk("t6_rst_top", top, 32'h0);
    cyc(0, 1, 0, 32'h42, 0);
    chk("t6_push_top", top, 32'h42);
    chk("t6_push_count", 32'(count), 1);
    cyc(0, 0, 1, '0, 0);
    chk("t6_pop_pd", pop_data, 32'h42);
    chk("t6_pop_empty", 32'(empty), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
